// File: rtl/memory_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; at most one read is outstanding.
// Optional macro ARB_ROUND_ROBIN_EN alternates the conflict winner; otherwise the data side always wins.
module memory_port_arbiter #(
   parameter int CORE            = 0,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDRESS_BITS    = 20,
   parameter int SCAN_CYCLES_MIN = 0,
   parameter int SCAN_CYCLES_MAX = 1000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    if_req,
   input  logic [ADDRESS_BITS-1:0] if_addr,
   output logic                    if_ready,
   output logic                    if_valid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    dm_load,
   input  logic                    dm_store,
   input  logic [ADDRESS_BITS-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0]   dm_wdata,
   output logic                    dm_ready,
   output logic                    dm_valid,
   output logic [DATA_WIDTH-1:0]   dm_rdata,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_ready,
   input  logic                    mem_valid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    scan
);

   typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        dm_req, prefer_dm, grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = data side won the most recent issue
   logic        last_dm_q, last_dm_d;
`endif

   always_comb begin
      dm_req    = dm_load | dm_store;
`ifdef ARB_ROUND_ROBIN_EN
      prefer_dm = ~last_dm_q;
`else
      prefer_dm = 1'b1;
`endif
      grant_dm  = dm_req & (~if_req | prefer_dm);

      state_d   = state_q;
      cnt_d     = cnt_q + 32'd1;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_d = last_dm_q;
`endif
      if_ready  = 1'b0;
      if_valid  = 1'b0;
      if_rdata  = '0;
      dm_ready  = 1'b0;
      dm_valid  = 1'b0;
      dm_rdata  = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      // Outputs are forced quiet while reset is held, regardless of inputs.
      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (mem_ready && (dm_req || if_req)) begin
                  if (grant_dm) begin
                     dm_ready  = 1'b1;
                     mem_addr  = dm_addr;
                     mem_wdata = dm_wdata;
                     if (dm_store) begin
                        mem_write = 1'b1;
                     end else begin
                        mem_read = 1'b1;
                        state_d  = D_WAIT;
                     end
                  end else begin
                     if_ready = 1'b1;
                     mem_read = 1'b1;
                     mem_addr = if_addr;
                     state_d  = I_WAIT;
                  end
`ifdef ARB_ROUND_ROBIN_EN
                  last_dm_d = grant_dm;
`endif
               end
            end
            I_WAIT: begin
               if (mem_valid) begin
                  if_valid = 1'b1;
                  if_rdata = mem_rdata;
                  state_d  = IDLE;
               end
            end
            D_WAIT: begin
               if (mem_valid) begin
                  dm_valid = 1'b1;
                  dm_rdata = mem_rdata;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_dm_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_dm_q <= last_dm_d;
`endif
      end
   end

`ifndef SYNTHESIS
   // Simulation-only trace of arbitration activity inside the scan window.
   always @(posedge clock) begin
      if (!reset && scan &&
          longint'(cnt_q) >= longint'(SCAN_CYCLES_MIN) &&
          longint'(cnt_q) <= longint'(SCAN_CYCLES_MAX)) begin
         $display("core%0d cyc=%0d state=%s if_gnt=%b dm_gnt=%b if_addr=%h dm_addr=%h mem_addr=%h",
                  CORE, cnt_q, state_q.name(), if_ready, dm_ready, if_addr, dm_addr, mem_addr);
      end
   end
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: vector table for single-cycle issue decisions plus
// hand-written multi-cycle sequences (response timing, store bypass, conflicts, backpressure, reset).
module tb_memory_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [19:0] if_addr;
   logic        if_ready, if_valid;
   logic [31:0] if_rdata;
   logic        dm_load, dm_store;
   logic [19:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ready, dm_valid;
   logic [31:0] dm_rdata;
   logic        mem_read, mem_write;
   logic [19:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready, mem_valid;
   logic [31:0] mem_rdata;
   logic        scan;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   memory_port_arbiter dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid), .if_rdata(if_rdata),
      .dm_load(dm_load), .dm_store(dm_store), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ready(dm_ready), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
      .scan(scan)
   );

   typedef struct {
      logic        if_req;
      logic [19:0] if_addr;
      logic        dm_load;
      logic        dm_store;
      logic [19:0] dm_addr;
      logic [31:0] dm_wdata;
      logic        mem_ready;
      logic [3:0]  exp_strb;   // {mem_read, mem_write, if_ready, dm_ready}
      logic [19:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [1:0]  exp_next;   // 0 idle, 1 fetch wait, 2 data wait
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      if_req = 1'b0; if_addr = '0;
      dm_load = 1'b0; dm_store = 1'b0; dm_addr = '0; dm_wdata = '0;
      mem_ready = 1'b1; mem_valid = 1'b0; mem_rdata = '0;
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clr();
      @(negedge clock);
      reset = 1'b0;
   endtask

   function automatic logic [3:0] strb();
      return {mem_read, mem_write, if_ready, dm_ready};
   endfunction

   initial begin
      vecs[0] = '{1'b1, 20'h100, 1'b0, 1'b0, 20'h0,   32'h0,    1'b1, 4'b1010, 20'h100, 32'h0,    2'd1};
      vecs[1] = '{1'b1, 20'h123, 1'b0, 1'b0, 20'h0,   32'h0,    1'b0, 4'b0000, 20'h0,   32'h0,    2'd0};
      vecs[2] = '{1'b0, 20'h0,   1'b1, 1'b0, 20'h200, 32'h0,    1'b1, 4'b1001, 20'h200, 32'h0,    2'd2};
      vecs[3] = '{1'b0, 20'h0,   1'b0, 1'b1, 20'h40,  32'hDEAD, 1'b1, 4'b0101, 20'h40,  32'hDEAD, 2'd0};
      vecs[4] = '{1'b0, 20'h0,   1'b1, 1'b1, 20'h80,  32'hBEEF, 1'b1, 4'b0101, 20'h80,  32'hBEEF, 2'd0};
`ifdef ARB_ROUND_ROBIN_EN
      vecs[5] = '{1'b1, 20'h300, 1'b1, 1'b0, 20'h304, 32'h0,    1'b1, 4'b1010, 20'h300, 32'h0,    2'd1};
      vecs[6] = '{1'b1, 20'h310, 1'b0, 1'b1, 20'h314, 32'h1234, 1'b1, 4'b1010, 20'h310, 32'h0,    2'd1};
`else
      vecs[5] = '{1'b1, 20'h300, 1'b1, 1'b0, 20'h304, 32'h0,    1'b1, 4'b1001, 20'h304, 32'h0,    2'd2};
      vecs[6] = '{1'b1, 20'h310, 1'b0, 1'b1, 20'h314, 32'h1234, 1'b1, 4'b0101, 20'h314, 32'h1234, 2'd0};
`endif
      vecs[7] = '{1'b0, 20'h0,   1'b0, 1'b0, 20'h0,   32'h0,    1'b1, 4'b0000, 20'h0,   32'h0,    2'd0};
      vecs[8] = '{1'b0, 20'h0,   1'b0, 1'b1, 20'h50,  32'h99,   1'b0, 4'b0000, 20'h0,   32'h0,    2'd0};

      scan = 1'b0;
      clr();
      reset = 1'b1;
      if_req = 1'b1; if_addr = 20'h100; dm_load = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h77;
      @(negedge clock);
      #1;
      chk("reset outputs", {strb(), if_valid, dm_valid, if_rdata, dm_rdata, mem_addr},
          {4'b0, 2'b0, 32'h0, 32'h0, 20'h0});
      do_reset();

      // Table: issue decision in IDLE, then the resulting state via a returned response.
      for (int i = 0; i < 9; i++) begin
         do_reset();
         if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
         dm_load = vecs[i].dm_load; dm_store = vecs[i].dm_store;
         dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
         mem_ready = vecs[i].mem_ready;
         #1;
         chk($sformatf("v%0d strobes", i), strb(), vecs[i].exp_strb);
         chk($sformatf("v%0d addr", i), mem_addr, vecs[i].exp_addr);
         chk($sformatf("v%0d wdata", i), mem_wdata, vecs[i].exp_wdata);
         cyc();
         clr();
         mem_valid = 1'b1; mem_rdata = 32'hCAFE0000 + i;
         #1;
         chk($sformatf("v%0d if_valid", i), if_valid, vecs[i].exp_next == 2'd1);
         chk($sformatf("v%0d dm_valid", i), dm_valid, vecs[i].exp_next == 2'd2);
         chk($sformatf("v%0d if_rdata", i), if_rdata,
             (vecs[i].exp_next == 2'd1) ? 32'hCAFE0000 + i : 32'h0);
         chk($sformatf("v%0d dm_rdata", i), dm_rdata,
             (vecs[i].exp_next == 2'd2) ? 32'hCAFE0000 + i : 32'h0);
         cyc();
         clr();
      end

      // Fetch: issue, one idle wait cycle, response, then immediate re-issue.
      do_reset();
      if_req = 1'b1; if_addr = 20'h100;
      #1;
      chk("fetch issue", {strb(), mem_addr}, {4'b1010, 20'h100});
      cyc();
      mem_rdata = 32'h55;
      #1;
      chk("fetch wait", {strb(), if_valid, if_rdata}, {4'b0000, 1'b0, 32'h0});
      cyc();
      mem_valid = 1'b1; mem_rdata = 32'h13;
      #1;
      chk("fetch resp", {strb(), if_valid, if_rdata}, {4'b0000, 1'b1, 32'h13});
      cyc();
      mem_valid = 1'b0;
      #1;
      chk("fetch reissue", strb(), 4'b1010);

      // Store stays in IDLE; fetch issues on the very next cycle.
      do_reset();
      dm_store = 1'b1; dm_addr = 20'h40; dm_wdata = 32'hDEAD;
      #1;
      chk("store issue", {strb(), mem_addr, mem_wdata}, {4'b0101, 20'h40, 32'hDEAD});
      cyc();
      clr();
      if_req = 1'b1; if_addr = 20'h104;
      #1;
      chk("fetch after store", {strb(), mem_addr}, {4'b1010, 20'h104});

      // Three back-to-back fetch/load conflicts.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         logic fetch_wins;
`ifdef ARB_ROUND_ROBIN_EN
         fetch_wins = (k != 1);
`else
         fetch_wins = 1'b0;
`endif
         if_req = 1'b1; if_addr = 20'h400; dm_load = 1'b1; dm_addr = 20'h500;
         mem_valid = 1'b0;
         #1;
         chk($sformatf("conflict%0d grant", k), {if_ready, dm_ready, mem_addr},
             {fetch_wins, ~fetch_wins, fetch_wins ? 20'h400 : 20'h500});
         cyc();
         mem_valid = 1'b1; mem_rdata = 32'h600 + k;
         #1;
         chk($sformatf("conflict%0d resp", k), {if_ready, dm_ready, if_valid, dm_valid},
             {2'b00, fetch_wins, ~fetch_wins});
         cyc();
      end
      clr();

      // Backpressure: five stalled cycles, then issue.
      do_reset();
      if_req = 1'b1; if_addr = 20'h180; mem_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("stall%0d", k), strb(), 4'b0000);
         cyc();
      end
      mem_ready = 1'b1;
      #1;
      chk("stall release", {strb(), mem_addr}, {4'b1010, 20'h180});

      // Reset while a load is outstanding drops the response.
      do_reset();
      dm_load = 1'b1; dm_addr = 20'h700;
      #1;
      chk("load issue", strb(), 4'b1001);
      cyc();
      clr();
      reset = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h77; if_req = 1'b1;
      #1;
      chk("reset in wait", {strb(), if_valid, dm_valid, dm_rdata}, {4'b0000, 2'b00, 32'h0});
      cyc();
      reset = 1'b0; if_req = 1'b0;
      #1;
      chk("stray valid", {dm_valid, dm_rdata, if_valid}, {1'b0, 32'h0, 1'b0});
      cyc();
      mem_valid = 1'b0; if_req = 1'b1; if_addr = 20'h10;
      #1;
      chk("idle after reset", {strb(), mem_addr}, {4'b1010, 20'h10});
      cyc();
      clr();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 SHALL have parameter CORE, default 0, core ID used in scan output.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the memory data bus.
REQ-003 SHALL have parameter ADDRESS_BITS, default 20, width of the byte address.
REQ-004 SHALL have parameter SCAN_CYCLES_MIN, default 0, first cycle of the scan window.
REQ-005 SHALL have parameter SCAN_CYCLES_MAX, default 1000, last cycle of the scan window.
REQ-006 SHALL have ports: clock  input  1  single clock, all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 if_req  input  1  fetch read request; if_addr  input  ADDRESS_BITS  fetch address.
REQ-009 if_ready  output  1  fetch request accepted this cycle; if_valid  output  1  fetch data valid; if_rdata  output  DATA_WIDTH  fetch data.
REQ-010 dm_load  input  1  data read request; dm_store  input  1  data write request; dm_addr  input  ADDRESS_BITS; dm_wdata  input  DATA_WIDTH.
REQ-011 dm_ready  output  1  data request accepted; dm_valid  output  1  load data valid; dm_rdata  output  DATA_WIDTH.
REQ-012 mem_read  output  1; mem_write  output  1; mem_addr  output  ADDRESS_BITS; mem_wdata  output  DATA_WIDTH; all four drive the shared memory port.
REQ-013 mem_ready  input  1  port can accept; mem_valid  input  1  read data returned; mem_rdata  input  DATA_WIDTH.
REQ-014 scan  input  1  enables state printout within the scan window.

Function
REQ-015 SHALL use a 3-state FSM: IDLE, I_WAIT, D_WAIT; at most one read outstanding.
REQ-016 In IDLE, a request is issued combinationally when mem_ready=1: the winner's read/write, address and wdata are driven onto mem_*, and that side's ready is 1 in the same cycle.
REQ-017 In IDLE with mem_ready=0, all mem_* strobes, if_ready and dm_ready SHALL be 0.
REQ-018 A fetch issue SHALL move IDLE->I_WAIT; a load issue SHALL move IDLE->D_WAIT; a store issue SHALL stay in IDLE (no response expected).
REQ-019 dm_load and dm_store both 1 SHALL be treated as a store only.
REQ-020 In I_WAIT/D_WAIT, no new request SHALL be issued; all ready outputs SHALL be 0.
REQ-021 In I_WAIT with mem_valid=1: if_valid=1, if_rdata=mem_rdata that cycle; next state IDLE. D_WAIT likewise with dm_valid/dm_rdata.
REQ-022 Minimum spacing: read issue in cycle N, response no earlier than N+1, next issue no earlier than the cycle after the response.
REQ-023 mem_valid in IDLE SHALL be ignored; no valid output pulses.
REQ-024 if_rdata/dm_rdata SHALL be 0 whenever the matching valid is 0.
REQ-025 A request deasserted before its ready SHALL leave no state behind.
REQ-026 A 32-bit cycle counter SHALL increment every cycle; when scan=1 and counter is within [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], state, grants and addresses SHALL be displayed each cycle.

Reset
REQ-027 Reset SHALL force state IDLE, last-grant register to data, cycle counter to 0, asynchronously.
REQ-028 During reset all outputs SHALL be 0; a pending response is dropped and a later stray mem_valid is ignored per REQ-023.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN defined: when fetch and data request in the same IDLE cycle, the side not granted last SHALL win; the last-grant register updates on every issue.
REQ-030 Macro ARB_ROUND_ROBIN_EN undefined: data side SHALL always win on conflict; the last-grant register is absent.

Verification
REQ-031 Fetch only: if_req=1, if_addr=0x100, mem_ready=1 -> mem_read=1, mem_addr=0x100, if_ready=1 same cycle; mem_valid=1, mem_rdata=0x13 two cycles later -> if_valid=1, if_rdata=0x13.
REQ-032 Store: dm_store=1, dm_addr=0x40, dm_wdata=0xDEAD -> mem_write=1, mem_wdata=0xDEAD, dm_ready=1; FSM stays IDLE; next-cycle fetch issues immediately.
REQ-033 Conflict: if_req=1, dm_load=1 together, three times back-to-back -> without macro data wins each time; with macro grants alternate fetch, data, fetch after reset.
REQ-034 Backpressure: mem_ready=0 for 5 cycles with if_req=1 -> no strobes, if_ready=0; mem_ready=1 -> issue that cycle.
REQ-035 Reset mid-op: load issued, reset asserted in D_WAIT, then mem_valid=1 after release -> dm_valid stays 0, state IDLE.
